outmux_sched: RTL and testbench
===============================

OUTMUX_SCHED -- requirements
Module: outmux_sched

Interface
REQ-001 The block SHALL have parameter HOLD_W, default 4, giving the width of the per-byte hold count.
REQ-002 The block SHALL have parameter WORD_W, default 32, giving the sample width; it is fixed at 4 bytes.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port ena, input, 1: global enable; low freezes all state.
REQ-006 Port mode, input, 1: 0 selects manual mode, 1 selects auto-scan mode.
REQ-007 Port man_sel, input, 2: byte select used in manual mode.
REQ-008 Port hold, input, HOLD_W: cycles per byte minus 1; it is sampled at frame start.
REQ-009 Port sample_valid, input, 1: one-cycle pulse marking a new decimated sample.
REQ-010 Port sample, input, WORD_W: decimated sample, qualified by sample_valid.
REQ-011 Port ovf_clr, input, 1: clears the sticky overrun flag.
REQ-012 Port word, output, WORD_W: shadow copy of the accepted sample; it drives the 4 byte lanes of the output mux (byte k = word[8k+7:8k]).
REQ-013 Port sel, output, 2: byte-lane select to the output mux.
REQ-014 Port byte_strb, output, 1: high on the first cycle each new byte is presented.
REQ-015 Port frame, output, 1: high on the first cycle of byte 0 of each frame.
REQ-016 Port busy, output, 1: high while an auto-scan frame is in progress.
REQ-017 Port ovf, output, 1: sticky overrun flag.

Function
REQ-018 The state machine SHALL have two states, IDLE and SCAN, plus a 2-bit byte index idx and a HOLD_W-bit down-counter cnt; all outputs SHALL be registered.
REQ-019 When ena=0, all state and outputs SHALL hold their values, sample_valid SHALL be ignored, and ovf SHALL NOT be set.
REQ-020 Auto mode, IDLE: sample_valid at cycle N SHALL give, at N+1: word=sample, sel=0, byte_strb=1, frame=1, busy=1, cnt=hold (latched), state SCAN.
REQ-021 SCAN: while cnt>0, cnt SHALL decrement and sel SHALL hold.
REQ-022 SCAN: when cnt=0 and idx<3, idx and sel SHALL increment, cnt SHALL reload the latched hold, and byte_strb SHALL pulse.
REQ-023 SCAN: when cnt=0 and idx=3, the block SHALL return to IDLE with sel=0 and busy=0.
REQ-024 Each byte SHALL be presented for hold+1 cycles; a frame SHALL last 4*(hold+1) cycles; hold=0 SHALL give 1 cycle per byte.
REQ-025 A sample_valid arriving in SCAN, other than on the final cycle, SHALL be dropped, leaving word unchanged, and SHALL set ovf.
REQ-026 A sample_valid on the final cycle (idx=3, cnt=0) SHALL start a new frame back-to-back: the next cycle shows sel=0, frame=1, busy stays 1, and ovf is not set.
REQ-027 In manual mode, sel SHALL equal the man_sel value registered the previous cycle.
REQ-028 In manual mode, each sample_valid SHALL load word the next cycle.
REQ-029 In manual mode, byte_strb, frame and busy SHALL be 0, and ovf SHALL NOT be set.
REQ-030 If mode falls to 0 during SCAN, the frame SHALL abort and the block SHALL enter IDLE the next cycle, with manual behaviour from that cycle.
REQ-031 If mode rises to 1, scanning SHALL wait for the next sample_valid.
REQ-032 ovf SHALL clear on ovf_clr.
REQ-033 If set and clear occur in the same cycle, set SHALL win.
REQ-034 A change on hold mid-frame SHALL NOT affect the current frame.

Reset
REQ-035 On a clk edge with rst_n=0 (regardless of ena), the block SHALL reset to: state IDLE, word=0, sel=0, idx=0, cnt=0, byte_strb=0, frame=0, busy=0, ovf=0.
REQ-036 A reset asserted mid-frame SHALL abort the frame with no further strobes.

Structure
REQ-037 The state encoding (IDLE, SCAN), the bytes-per-word constant (4) and the byte-lane width (8) SHALL live in the shared filter package.
REQ-038 No sub-module is needed; outmux_sched feeds the existing output mux instance at top level.

Verification
REQ-039 Scenario 1: auto mode, hold=2, sample=0xA1B2C3D4 pulsed -> sel sequence 0,0,0,1,1,1,2,2,2,3,3,3, then 0; byte_strb at cycles 1,4,7,10; frame at cycle 1; busy for 12 cycles.
REQ-040 Scenario 2: hold=0, two pulses 4 cycles apart (back-to-back) -> sel 0,1,2,3,0,1,2,3; busy stays high for 8 cycles; ovf=0.
REQ-041 Scenario 3: pulse at frame cycle 2 with hold=1 -> word unchanged, ovf=1; ovf_clr and a new overrun in the same cycle -> ovf stays 1; ovf_clr alone -> ovf=0.
REQ-042 Scenario 4: manual mode, man_sel=2, sample=0x11223344 -> word=0x11223344 and sel=2 the next cycle; no strobes.
REQ-043 Scenario 5: mode dropped to 0 at frame cycle 5 -> IDLE the next cycle, busy=0, sel follows man_sel.
REQ-044 Scenario 6: ena=0 for 3 cycles mid-frame -> sel/cnt frozen and a pulse during that window is ignored; then rst_n=0 mid-frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/outmux_sched_pkg.sv
// Shared constants and state encoding for the output-mux byte scheduler.
package outmux_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam logic [1:0]  LAST_IDX       = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/outmux_sched.sv
// Byte-lane scheduler: shadows a decimated sample and steps the output-mux
// select through its bytes, either automatically per sample or by hand.
module outmux_sched
    import outmux_sched_pkg::*;
#(
    parameter int HOLD_W = 4,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              mode,
    input  logic [1:0]        man_sel,
    input  logic [HOLD_W-1:0] hold,
    input  logic              sample_valid,
    input  logic [WORD_W-1:0] sample,
    input  logic              ovf_clr,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        sel,
    output logic              byte_strb,
    output logic              frame,
    output logic              busy,
    output logic              ovf
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_lat_q, hold_lat_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        sel_q, sel_d;
    logic              byte_strb_q, byte_strb_d;
    logic              frame_q, frame_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              start;
    logic              ovf_set;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        hold_lat_d  = hold_lat_q;
        word_d      = word_q;
        sel_d       = sel_q;
        byte_strb_d = byte_strb_q;
        frame_d     = frame_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        start       = 1'b0;
        ovf_set     = 1'b0;

        if (ena) begin
            byte_strb_d = 1'b0;
            frame_d     = 1'b0;
            if (!mode) begin
                // Manual mode also serves as the abort path out of SCAN.
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
                sel_d   = man_sel;
                if (sample_valid) begin
                    word_d = sample;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        busy_d = 1'b0;
                        start  = sample_valid;
                    end
                    SCAN: begin
                        if (cnt_q != '0) begin
                            cnt_d   = cnt_q - 1'b1;
                            ovf_set = sample_valid;
                        end else if (idx_q != LAST_IDX) begin
                            idx_d       = idx_q + 2'd1;
                            sel_d       = sel_q + 2'd1;
                            cnt_d       = hold_lat_q;
                            byte_strb_d = 1'b1;
                            ovf_set     = sample_valid;
                        end else if (sample_valid) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                            sel_d   = '0;
                            busy_d  = 1'b0;
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (start) begin
                    state_d     = SCAN;
                    word_d      = sample;
                    sel_d       = '0;
                    idx_d       = '0;
                    cnt_d       = hold;
                    hold_lat_d  = hold;
                    byte_strb_d = 1'b1;
                    frame_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            // A fresh overrun outranks a simultaneous clear.
            ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            hold_lat_q  <= '0;
            word_q      <= '0;
            sel_q       <= '0;
            byte_strb_q <= 1'b0;
            frame_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            hold_lat_q  <= hold_lat_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            byte_strb_q <= byte_strb_d;
            frame_q     <= frame_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign word      = word_q;
    assign sel       = sel_q;
    assign byte_strb = byte_strb_q;
    assign frame     = frame_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_outmux_sched.sv
// Scoreboard bench for outmux_sched: directed stimulus queues cycle-tagged
// expectations and strobe records; monitors pop and compare.
module tb_outmux_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        mode;
    logic [1:0]  man_sel;
    logic [3:0]  hold;
    logic        sample_valid;
    logic [31:0] sample;
    logic        ovf_clr;
    logic [31:0] word;
    logic [1:0]  sel;
    logic        byte_strb;
    logic        frame;
    logic        busy;
    logic        ovf;

    outmux_sched #(
        .HOLD_W(4),
        .WORD_W(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .mode        (mode),
        .man_sel     (man_sel),
        .hold        (hold),
        .sample_valid(sample_valid),
        .sample      (sample),
        .ovf_clr     (ovf_clr),
        .word        (word),
        .sel         (sel),
        .byte_strb   (byte_strb),
        .frame       (frame),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [31:0] w;
        logic [1:0]  s;
        logic        st;
        logic        fr;
        logic        bs;
        logic        ov;
        string       nm;
    } exp_t;

    typedef struct {
        logic [1:0]  s;
        logic        fr;
        logic [31:0] w;
    } strb_t;

    exp_t  exp_q[$];
    strb_t strb_q[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;
    logic  ena_s;

    task automatic ex(input int c, input logic [31:0] w, input logic [1:0] s,
                      input logic st, input logic fr, input logic bs,
                      input logic ov, input string nm);
        exp_t e;
        e.c = c; e.w = w; e.s = s; e.st = st; e.fr = fr; e.bs = bs; e.ov = ov; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic sx(input logic [1:0] s, input logic fr, input logic [31:0] w);
        strb_t t;
        t.s = s; t.fr = fr; t.w = w;
        strb_q.push_back(t);
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Output monitor: cycle-tagged snapshots plus a strobe-triggered check.
    initial begin
        forever begin
            @(posedge clk);
            ena_s = ena;
            cyc++;
            #2;
            while (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
                exp_t e;
                logic [37:0] act, want;
                e    = exp_q.pop_front();
                act  = {word, sel, byte_strb, frame, busy, ovf};
                want = {e.w, e.s, e.st, e.fr, e.bs, e.ov};
                checks++;
                if (act !== want || e.c != cyc) begin
                    failures++;
                    $display("FAIL %s cyc=%0d(due %0d) got word=%h sel=%0d strb=%b frame=%b busy=%b ovf=%b want word=%h sel=%0d strb=%b frame=%b busy=%b ovf=%b",
                             e.nm, cyc, e.c, word, sel, byte_strb, frame, busy, ovf,
                             e.w, e.s, e.st, e.fr, e.bs, e.ov);
                end
            end
            if (byte_strb === 1'b1 && ena_s === 1'b1) begin
                checks++;
                if (strb_q.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_unexpected cyc=%0d got sel=%0d frame=%b word=%h want no strobe",
                             cyc, sel, frame, word);
                end else begin
                    strb_t t;
                    t = strb_q.pop_front();
                    if ({sel, frame, word} !== {t.s, t.fr, t.w}) begin
                        failures++;
                        $display("FAIL strobe cyc=%0d got sel=%0d frame=%b word=%h want sel=%0d frame=%b word=%h",
                                 cyc, sel, frame, word, t.s, t.fr, t.w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no completion want completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        rst_n = 1'b0; ena = 1'b1; mode = 1'b1; man_sel = 2'd0; hold = 4'd0;
        sample_valid = 1'b0; sample = '0; ovf_clr = 1'b0;

        // Reset
        step;
        ex(cyc + 1, 32'h0, 2'd0, 0, 0, 0, 0, "reset");
        step;
        rst_n = 1'b1;
        ex(cyc + 1, 32'h0, 2'd0, 0, 0, 0, 0, "post_reset_idle");

        // Scenario 1: hold=2, single frame; hold changed mid-frame
        step;
        c0 = cyc;
        hold = 4'd2; sample = 32'hA1B2C3D4; sample_valid = 1'b1;
        for (int k = 1; k <= 12; k++)
            ex(c0 + k, 32'hA1B2C3D4, 2'((k - 1) / 3), ((k - 1) % 3) == 0, k == 1, 1, 0, "s1_scan");
        ex(c0 + 13, 32'hA1B2C3D4, 2'd0, 0, 0, 0, 0, "s1_end");
        for (int k = 0; k < 4; k++) sx(2'(k), k == 0, 32'hA1B2C3D4);
        step;
        sample_valid = 1'b0; hold = 4'd5;
        wait_to(c0 + 13);

        // Scenario 2: hold=0, back-to-back frames
        c0 = cyc;
        hold = 4'd0; sample = 32'h0BADF00D; sample_valid = 1'b1;
        for (int k = 1; k <= 4; k++)
            ex(c0 + k, 32'h0BADF00D, 2'(k - 1), 1, k == 1, 1, 0, "s2_frame_a");
        for (int k = 5; k <= 8; k++)
            ex(c0 + k, 32'h12345678, 2'(k - 5), 1, k == 5, 1, 0, "s2_frame_b");
        ex(c0 + 9, 32'h12345678, 2'd0, 0, 0, 0, 0, "s2_end");
        for (int k = 0; k < 4; k++) sx(2'(k), k == 0, 32'h0BADF00D);
        for (int k = 0; k < 4; k++) sx(2'(k), k == 0, 32'h12345678);
        step;
        sample_valid = 1'b0;
        wait_to(c0 + 4);
        sample = 32'h12345678; sample_valid = 1'b1;
        step;
        sample_valid = 1'b0;
        wait_to(c0 + 9);

        // Scenario 3: overrun, set-beats-clear, then clear
        c0 = cyc;
        hold = 4'd1; sample = 32'hCAFE0001; sample_valid = 1'b1;
        for (int k = 1; k <= 8; k++)
            ex(c0 + k, 32'hCAFE0001, 2'((k - 1) / 2), ((k - 1) % 2) == 0, k == 1, 1,
               (k >= 3 && k <= 6), "s3_ovf");
        ex(c0 + 9, 32'hCAFE0001, 2'd0, 0, 0, 0, 0, "s3_end");
        for (int k = 0; k < 4; k++) sx(2'(k), k == 0, 32'hCAFE0001);
        step;
        sample_valid = 1'b0;
        wait_to(c0 + 2);
        sample = 32'hDEADBEEF; sample_valid = 1'b1;
        step;
        sample_valid = 1'b0;
        step;
        sample = 32'h01010101; sample_valid = 1'b1; ovf_clr = 1'b1;
        step;
        sample_valid = 1'b0; ovf_clr = 1'b0;
        step;
        ovf_clr = 1'b1;
        step;
        ovf_clr = 1'b0;
        wait_to(c0 + 9);

        // Scenario 4: manual mode
        c0 = cyc;
        mode = 1'b0; man_sel = 2'd2; sample = 32'h11223344; sample_valid = 1'b1;
        ex(c0 + 1, 32'h11223344, 2'd2, 0, 0, 0, 0, "s4_load");
        ex(c0 + 2, 32'h11223344, 2'd1, 0, 0, 0, 0, "s4_sel");
        ex(c0 + 3, 32'h99887766, 2'd1, 0, 0, 0, 0, "s4_reload");
        step;
        man_sel = 2'd1; sample_valid = 1'b0;
        step;
        sample = 32'h99887766; sample_valid = 1'b1;
        step;
        sample_valid = 1'b0;

        // Scenario 5: mode rises (waits for pulse), then abort at frame cycle 5
        c0 = cyc;
        mode = 1'b1; man_sel = 2'd3;
        ex(c0 + 1, 32'h99887766, 2'd1, 0, 0, 0, 0, "s5_wait");
        step;
        c1 = cyc;
        hold = 4'd2; sample = 32'h55AA55AA; sample_valid = 1'b1;
        for (int k = 1; k <= 5; k++)
            ex(c1 + k, 32'h55AA55AA, 2'((k - 1) / 3), ((k - 1) % 3) == 0, k == 1, 1, 0, "s5_scan");
        ex(c1 + 6, 32'h55AA55AA, 2'd3, 0, 0, 0, 0, "s5_abort");
        ex(c1 + 7, 32'h55AA55AA, 2'd0, 0, 0, 0, 0, "s5_manual");
        sx(2'd0, 1'b1, 32'h55AA55AA);
        sx(2'd1, 1'b0, 32'h55AA55AA);
        step;
        sample_valid = 1'b0;
        wait_to(c1 + 5);
        mode = 1'b0;
        step;
        man_sel = 2'd0;
        step;

        // Scenario 6: freeze with ena=0, then reset mid-frame
        c0 = cyc;
        mode = 1'b1; hold = 4'd1; sample = 32'h0F0F0F0F; sample_valid = 1'b1;
        ex(c0 + 1, 32'h0F0F0F0F, 2'd0, 1, 1, 1, 0, "s6_scan");
        ex(c0 + 2, 32'h0F0F0F0F, 2'd0, 0, 0, 1, 0, "s6_scan");
        ex(c0 + 3, 32'h0F0F0F0F, 2'd1, 1, 0, 1, 0, "s6_scan");
        for (int k = 4; k <= 6; k++)
            ex(c0 + k, 32'h0F0F0F0F, 2'd1, 1, 0, 1, 0, "s6_frozen");
        ex(c0 + 7, 32'h0F0F0F0F, 2'd1, 0, 0, 1, 0, "s6_resume");
        ex(c0 + 8, 32'h0F0F0F0F, 2'd2, 1, 0, 1, 0, "s6_resume");
        ex(c0 + 9, 32'h0, 2'd0, 0, 0, 0, 0, "s6_reset");
        ex(c0 + 10, 32'h0, 2'd0, 0, 0, 0, 0, "s6_reset_noena");
        ex(c0 + 11, 32'h0, 2'd0, 0, 0, 0, 0, "s6_after_reset");
        sx(2'd0, 1'b1, 32'h0F0F0F0F);
        sx(2'd1, 1'b0, 32'h0F0F0F0F);
        sx(2'd2, 1'b0, 32'h0F0F0F0F);
        step;
        sample_valid = 1'b0;
        wait_to(c0 + 3);
        ena = 1'b0;
        step;
        sample = 32'hFFFFFFFF; sample_valid = 1'b1;
        step;
        sample_valid = 1'b0;
        step;
        ena = 1'b1;
        wait_to(c0 + 8);
        rst_n = 1'b0;
        step;
        ena = 1'b0; sample = 32'h77777777; sample_valid = 1'b1;
        step;
        rst_n = 1'b1; ena = 1'b1; sample_valid = 1'b0;
        wait_to(c0 + 12);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step;
        step;
        checks++;
        if (exp_q.size() != 0 || strb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending_exp=%0d pending_strobes=%0d want 0 and 0",
                     exp_q.size(), strb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
